ddr3_mem_responder: RTL

- Synthesizable device-side DDR3 responder for emulation: the memory end of the controller's command/data interface.
- Decodes ACT/RD/WR/PRE on the command pins, tracks one open row per bank, and stores 64-bit bursts (BL8 x 8-bit) in an internal array.
- Accepts write data and returns read data as 16-bit words (two DDR beats per ck), matching the controller's x8 ODDR/IDDR packing.
- Sits between the controller's pin interface and the emulation top, in place of a DRAM model.

---
 rtl/ddr3_mem_responder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ddr3_mem_responder.sv
// DDR3 device-side responder: ACT/RD/WR/PRE decode, per-bank open row, BL8 x8 bursts as 16-bit words; WL/RL latency from the command edge.
// No backpressure: RD/WR while busy or to a closed bank are dropped and flag o_err; byte masking is enabled by DDR3_DM_EN.
module ddr3_mem_responder #(
  parameter int ROW_BITS = 2,
  parameter int WL       = 9,
  parameter int RL       = 13
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [2:0]  ba,
  input  logic [12:0] addr,
  input  logic [15:0] i_wdata,
  input  logic [1:0]  i_dm,
  output logic [15:0] o_rdata,
  output logic        o_rdata_oe,
  output logic        o_busy,
  output logic        o_err
);

  localparam int IDX_W = 3 + ROW_BITS + 7;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [4:0] WL_M1  = 5'(WL - 1);
  localparam logic [4:0] WL_END = 5'(WL + 3);
  localparam logic [4:0] RL_M1  = 5'(RL - 1);
  localparam logic [4:0] RL_END = 5'(RL + 3);

  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_DATA, RD_WAIT, RD_DATA} state_t;

  state_t               state, state_nxt;
  logic [4:0]           cnt;
  logic [2:0]           rcw;
  logic                 cmd_en, is_act, is_rd, is_wr, is_pre;
  logic                 busy, bank_hit, rd_ok, wr_ok;
  logic                 capture, commit, rd_drive;
  logic [7:0]           bank_open;
  logic [ROW_BITS-1:0]  bank_row [8];
  logic [IDX_W-1:0]     cmd_idx, acc_idx;
  logic [63:0]          hold;
  logic [63:0]          mem [DEPTH];
  logic [4:0]           wr_off, rd_off;
  logic [5:0]           wr_lsb, rd_lsb;
  logic                 unused_ok;

  assign unused_ok = ^{addr, i_dm};

  assign rcw    = {ras_n, cas_n, we_n};
  assign cmd_en = cke & ~cs_n;
  assign is_act = cmd_en && (rcw == 3'b011);
  assign is_rd  = cmd_en && (rcw == 3'b101);
  assign is_wr  = cmd_en && (rcw == 3'b100);
  assign is_pre = cmd_en && (rcw == 3'b010);

  assign busy     = (state != IDLE);
  assign bank_hit = bank_open[ba];
  assign rd_ok    = is_rd && !busy && bank_hit;
  assign wr_ok    = is_wr && !busy && bank_hit;
  assign cmd_idx  = {ba, bank_row[ba], addr[9:3]};
  assign o_busy   = busy;

  // cnt holds (edges since command - 1), so the beat index falls out of a subtract.
  assign wr_off = cnt - WL_M1;
  assign rd_off = cnt - RL_M1;
  assign wr_lsb = {wr_off[1:0], 4'b0000};
  assign rd_lsb = {rd_off[1:0], 4'b0000};

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    commit    = 1'b0;
    rd_drive  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ok)      state_nxt = WR_WAIT;
        else if (rd_ok) state_nxt = RD_WAIT;
      end
      WR_WAIT: begin
        if (cnt == WL_M1) begin
          capture   = 1'b1;
          state_nxt = WR_DATA;
        end
      end
      WR_DATA: begin
        if (cnt == WL_END) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end else begin
          capture = 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt == RL_M1) begin
          rd_drive  = 1'b1;
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        if (cnt == RL_END) state_nxt = IDLE;
        else               rd_drive  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else                    cnt <= cnt + 5'd1;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      bank_open <= '0;
      for (int i = 0; i < 8; i++) bank_row[i] <= '0;
    end else if (is_act) begin
      bank_open[ba] <= 1'b1;
      bank_row[ba]  <= addr[ROW_BITS-1:0];
    end else if (is_pre) begin
      if (addr[10]) bank_open     <= '0;
      else          bank_open[ba] <= 1'b0;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      acc_idx    <= '0;
      o_err      <= 1'b0;
      o_rdata    <= '0;
      o_rdata_oe <= 1'b0;
    end else begin
      if (rd_ok || wr_ok)                          acc_idx <= cmd_idx;
      if ((is_rd || is_wr) && (busy || !bank_hit)) o_err   <= 1'b1;
      o_rdata_oe <= rd_drive;
      o_rdata    <= rd_drive ? hold[rd_lsb +: 16] : 16'h0000;
    end
  end

  // Array and holding register carry no reset so contents survive rst_n;
  // commit depends on the reset state register, so an aborted write never lands.
  always_ff @(posedge ck) begin
    if (rd_ok || wr_ok) begin
      hold <= mem[cmd_idx];
    end else if (capture) begin
`ifdef DDR3_DM_EN
      if (!i_dm[0]) hold[wr_lsb +: 8]         <= i_wdata[7:0];
      if (!i_dm[1]) hold[wr_lsb + 6'd8 +: 8]  <= i_wdata[15:8];
`else
      hold[wr_lsb +: 16] <= i_wdata;
`endif
    end
    if (commit) mem[acc_idx] <= hold;
  end

endmodule
